// File: rtl/muldiv_unit_pkg.sv
// Shared op codes, FSM state codes and stall encoding for the iterative multiply/divide unit.
package muldiv_unit_pkg;
    localparam int MD_OP_WD = 2;

    typedef enum logic [MD_OP_WD-1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;
endpackage

// File: rtl/muldiv_negabs.sv
// Conditional two's-complement negate; combinational, zero latency, no flow control.
module muldiv_negabs #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);
    assign o_val = i_neg ? ((~i_val) + W'(1)) : i_val;
endmodule

// File: rtl/muldiv_unit.sv
// Shared shift-add multiplier / restoring divider: WIDTH+1 cycles to ready_o (1 for divide-by-zero).
// Start is held by EX until ready_o; stallreq_o holds EX back meanwhile, annul_i aborts without a result.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH+1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [MD_OP_WD-1:0] op_i,
    input  logic [WIDTH-1:0]    opa_i,
    input  logic [WIDTH-1:0]    opb_i,
    input  logic                annul_i,
    output logic                busy_o,
    output logic                ready_o,
    output logic                stallreq_o,
    output logic [WIDTH-1:0]    hi_o,
    output logic [WIDTH-1:0]    lo_o,
    output logic                div_by_zero_o
);
    md_state_e          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    logic               r_sign_a;
    logic               r_sign_b;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_dbz;

    logic               w_op_div;
    logic               w_op_signed;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_new;
    logic [2*WIDTH-1:0] w_mul_nxt;
    logic [2*WIDTH-1:0] w_div_nxt;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_op_div    = (op_i == MD_DIV) || (op_i == MD_DIVU);
    assign w_op_signed = (op_i == MD_MULT) || (op_i == MD_DIV);
    assign w_sa        = w_op_signed & opa_i[WIDTH-1];
    assign w_sb        = w_op_signed & opb_i[WIDTH-1];

    muldiv_negabs #(.W(WIDTH)) u_abs_a (.i_val(opa_i), .i_neg(w_sa), .o_val(w_a_abs));
    muldiv_negabs #(.W(WIDTH)) u_abs_b (.i_val(opb_i), .i_neg(w_sb), .o_val(w_b_abs));

    // Multiply: acc = {partial sum, remaining multiplier bits}, one bit consumed per cycle.
    assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    assign w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    assign w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_b});
    assign w_rem_new = w_ge ? WIDTH'(w_rem_sh - {1'b0, r_b}) : w_rem_sh[WIDTH-1:0];
    assign w_div_nxt = {w_rem_new, r_acc[WIDTH-2:0], w_ge};

    assign w_acc_nxt = r_is_div ? w_div_nxt : w_mul_nxt;

    muldiv_negabs #(.W(2*WIDTH)) u_fix_prod (
        .i_val(w_acc_nxt), .i_neg(r_sign_a ^ r_sign_b), .o_val(w_prod_fix));
    muldiv_negabs #(.W(WIDTH)) u_fix_quo (
        .i_val(w_acc_nxt[WIDTH-1:0]), .i_neg(r_sign_a ^ r_sign_b), .o_val(w_quo_fix));
    muldiv_negabs #(.W(WIDTH)) u_fix_rem (
        .i_val(w_acc_nxt[2*WIDTH-1:WIDTH]), .i_neg(r_sign_a), .o_val(w_rem_fix));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= MD_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_b      <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_dbz    <= 1'b0;
        end else if (annul_i) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                MD_IDLE: begin
                    if (start_i) begin
                        r_is_div <= w_op_div;
                        r_sign_a <= w_sa;
                        r_sign_b <= w_sb;
                        r_cnt    <= '0;
                        r_dbz    <= 1'b0;
                        if (w_op_div && (opb_i == '0)) begin
                            r_hi    <= opa_i;
                            r_lo    <= '1;
                            r_dbz   <= 1'b1;
                            r_state <= MD_DONE;
                        end else begin
                            r_b     <= w_op_div ? w_b_abs : w_a_abs;
                            r_acc   <= {{WIDTH{1'b0}}, (w_op_div ? w_a_abs : w_b_abs)};
                            r_state <= MD_CALC;
                        end
                    end
                end
                MD_CALC: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH-1)) begin
                        r_cnt   <= '0;
                        r_state <= MD_DONE;
                        if (r_is_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end else begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end
                    end
                end
                MD_DONE: r_state <= MD_IDLE;
                default: r_state <= MD_IDLE;
            endcase
        end
    end

    assign busy_o        = (r_state != MD_IDLE);
    assign ready_o       = (r_state == MD_DONE);
    assign stallreq_o    = (start_i & ~ready_o) ? STOP : NO_STOP;
    assign hi_o          = r_hi;
    assign lo_o          = r_lo;
    assign div_by_zero_o = r_dbz;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at WIDTH=32: directed vectors, random vs arithmetic model, annul and async reset.
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [1:0]   op_i;
    logic [W-1:0] opa_i;
    logic [W-1:0] opb_i;
    logic         annul_i;
    logic         busy_o;
    logic         ready_o;
    logic         stallreq_o;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;
    logic         div_by_zero_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .opa_i(opa_i), .opb_i(opb_i), .annul_i(annul_i),
        .busy_o(busy_o), .ready_o(ready_o), .stallreq_o(stallreq_o),
        .hi_o(hi_o), .lo_o(lo_o), .div_by_zero_o(div_by_zero_o)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic; SV division truncates toward zero and % follows the dividend.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
        longint      sa, sb, sp;
        logic [63:0] up;
        dbz = 1'b0;
        sa  = $signed(a);
        sb  = $signed(b);
        case (op)
            2'b00: begin sp = sa * sb; {hi, lo} = sp; end
            2'b01: begin up = {32'b0, a} * {32'b0, b}; {hi, lo} = up; end
            default: begin
                if (b == 32'd0) begin
                    hi = a; lo = 32'hFFFF_FFFF; dbz = 1'b1;
                end else if (op == 2'b10) begin
                    lo = 32'(sa / sb); hi = 32'(sa % sb);
                end else begin
                    lo = a / b; hi = a % b;
                end
            end
        endcase
    endfunction

    // Holds start until ready; scrambles operands mid-flight to show they are ignored.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] ghi, output logic [31:0] glo, output logic gdbz,
                         output int lat, output int stall);
        @(negedge clk);
        start_i = 1'b1; op_i = op; opa_i = a; opb_i = b;
        lat = 0; stall = 0;
        forever begin
            #1;
            if (stallreq_o) stall++;
            if (ready_o || lat >= 100) break;
            @(negedge clk);
            lat++;
            if (lat == 2) begin
                op_i = 2'($urandom); opa_i = $urandom; opb_i = $urandom;
            end
        end
        ghi = hi_o; glo = lo_o; gdbz = div_by_zero_o;
        start_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ghi, glo, ehi, elo;
        logic        gdbz, edbz, seen;
        int          lat, stall;

        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = '0; opa_i = '0; opb_i = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset busy", busy_o, 0);
        check("reset ready", ready_o, 0);
        check("reset hi", hi_o, 0);
        check("reset lo", lo_o, 0);
        check("reset dbz", div_by_zero_o, 0);
        check("reset stall", stallreq_o, 0);
        rst = 1'b0;

        vecs[0] = '{2'b00, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33};
        vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33};
        vecs[3] = '{2'b11, 32'h8000_0000, 32'd3,        32'd2,         32'h2AAA_AAAA, 1'b0, 33};
        vecs[4] = '{2'b10, 32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1'b1, 1};
        vecs[5] = '{2'b11, 32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1};
        vecs[6] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 1'b0, 33};
        vecs[7] = '{2'b10, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2,        1'b0, 33};
        vecs[8] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        1'b0, 33};
        vecs[9] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0, 33};

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, ghi, glo, gdbz, lat, stall);
            check($sformatf("vec%0d hi", i), ghi, vecs[i].hi);
            check($sformatf("vec%0d lo", i), glo, vecs[i].lo);
            check($sformatf("vec%0d dbz", i), gdbz, vecs[i].dbz);
            check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d stall cycles", i), stall, vecs[i].lat);
            @(negedge clk);
            #1;
            check($sformatf("vec%0d ready pulse", i), ready_o, 0);
            check($sformatf("vec%0d hold hi", i), hi_o, vecs[i].hi);
            check($sformatf("vec%0d hold lo", i), lo_o, vecs[i].lo);
        end

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            int          k;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            k  = $urandom_range(0, 9);
            if (k == 0) b = 32'd0;
            else if (k == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (k == 2) b = 32'($urandom_range(1, 15));
            else if (k == 3) b = -32'($urandom_range(1, 15));
            model(op, a, b, ehi, elo, edbz);
            do_op(op, a, b, ghi, glo, gdbz, lat, stall);
            check($sformatf("rnd%0d op%0d %h,%h hi", i, op, a, b), ghi, ehi);
            check($sformatf("rnd%0d op%0d %h,%h lo", i, op, a, b), glo, elo);
            check($sformatf("rnd%0d dbz", i), gdbz, edbz);
            check($sformatf("rnd%0d latency", i), lat, edbz ? 1 : 33);
        end

        // Annul mid-CALC: no result, previous hi/lo survive.
        do_op(2'b00, 32'hFFFF_FFFD, 32'd7, ghi, glo, gdbz, lat, stall);
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b01; opa_i = 32'd123456; opb_i = 32'd654321;
        repeat (10) @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        #1;
        check("annul busy", busy_o, 0);
        check("annul ready", ready_o, 0);
        check("annul hi kept", hi_o, 32'hFFFF_FFFF);
        check("annul lo kept", lo_o, 32'hFFFF_FFEB);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (ready_o) seen = 1'b1;
        end
        check("annul no ready", seen, 0);
        do_op(2'b01, 32'd6, 32'd7, ghi, glo, gdbz, lat, stall);
        check("after annul lo", glo, 32'd42);
        check("after annul hi", ghi, 32'd0);

        // Async reset between edges in the middle of a divide.
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b10; opa_i = 32'd1000; opb_i = 32'd7;
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async rst busy", busy_o, 0);
        check("async rst ready", ready_o, 0);
        check("async rst hi", hi_o, 0);
        check("async rst lo", lo_o, 0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, ghi, glo, gdbz, lat, stall);
        check("minneg/-1 lo", glo, 32'h8000_0000);
        check("minneg/-1 hi", ghi, 32'd0);
        check("minneg/-1 dbz", gdbz, 0);
        check("minneg/-1 latency", lat, 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit for the EX stage. It replaces the fixed 32-bit divider and separate multiplier with one shared shift-add / restoring-division datapath. It supports signed and unsigned multiply and divide, annulment, and divide-by-zero detection. EX drives it with a start/ready handshake, raises a stall request while it runs, and forwards `{hi_o, lo_o}` to the HI/LO write path.

## Interface

Parameters:
- `WIDTH`, default 32. Operand width, minimum 4.
- `CNT_W`, default `$clog2(WIDTH+1)`. Iteration counter width.

Ports:
- `clk` input, 1. Single clock; all state updates on the rising edge.
- `rst` input, 1. Asynchronous, active-high reset.
- `start_i` input, 1. Operation request. EX holds it high until `ready_o`.
- `op_i` input, 2. Operation: 00 `MULT`, 01 `MULTU`, 10 `DIV`, 11 `DIVU`.
- `opa_i` input, `WIDTH`. Multiplicand or dividend (rs).
- `opb_i` input, `WIDTH`. Multiplier or divisor (rt).
- `annul_i` input, 1. Abort the operation in flight.
- `busy_o` output, 1. State is not `IDLE`.
- `ready_o` output, 1. One-cycle pulse; `hi_o`/`lo_o` are valid.
- `stallreq_o` output, 1. `start_i & ~ready_o`; drives `stallreq_for_ex`.
- `hi_o` output, `WIDTH`. Product high half, or remainder.
- `lo_o` output, `WIDTH`. Product low half, or quotient.
- `div_by_zero_o` output, 1. Set with `ready_o` when a divide had `opb_i == 0`.

## Operation

- States: `IDLE`, `CALC`, `DONE`.
- **Accept.** In `IDLE` with `start_i=1` and `annul_i=0`, capture `op_i`, `|opa_i|` and `|opb_i|`, plus the result-sign flags. Unsigned ops use raw values and clear the sign flags. Go to `CALC` with `cnt=0`.
- **Divide by zero.** A `DIV`/`DIVU` with `opb_i=0` goes from `IDLE` straight to `DONE`:
  - `hi_o = opa_i`
  - `lo_o = {WIDTH{1'b1}}`
  - `div_by_zero_o = 1`
- **Multiply (`CALC`).** Shift-add, one multiplier bit per cycle, LSB first, into a 2·`WIDTH` accumulator. `WIDTH` iterations.
- **Divide (`CALC`).** Restoring division, one quotient bit per cycle, MSB first. Partial remainder is `WIDTH+1` bits. `WIDTH` iterations.
- **`CALC` → `DONE`** when `cnt == WIDTH-1` at the edge. That edge also applies sign correction and registers `hi_o`/`lo_o`:
  - Signed product: negate the 2·`WIDTH` result if the operand signs differ.
  - Quotient: negative if the operand signs differ.
  - Remainder: takes the sign of the dividend.
  - Min-negative ÷ −1 gives `lo_o` = min-negative and `hi_o` = 0 (wraps, no trap).
- **`DONE`.** `ready_o=1` for exactly this cycle, then `IDLE` on the next edge.
- **Result hold.** `hi_o`, `lo_o` and `div_by_zero_o` keep their values until the next `DONE`. `div_by_zero_o` is cleared at the next accept.
- **Annul.** `annul_i=1` in any state returns to `IDLE` at the next edge. There is no `ready_o` and outputs keep their previous values. `annul_i` has priority over `start_i` and over the `DONE` transition.
- **Back-to-back.** `start_i` seen in the cycle after `DONE` (now `IDLE`) is a new accept. A re-run of the same held instruction recomputes the identical result.
- **Operand changes.** Changes to `op_i`, `opa_i` or `opb_i` after accept are ignored.
- **Reset values.** State `IDLE`, `cnt=0`, and all outputs 0.

## Timing

- **Latency.** With the accept at edge *k*, `ready_o` is high in the cycle after edge *k*+`WIDTH`. That is `WIDTH+1` cycles for mult/div, and 1 cycle for divide-by-zero.
- **Stall.** `stallreq_o` is combinational and high from the first cycle `start_i` is seen until the `ready_o` cycle, exclusive of that cycle. The EX register advances on the `ready_o` cycle.
- **Reset mid-operation.** `rst` asserted in any state forces `IDLE` and zero outputs immediately (asynchronous). Operation resumes on the first edge after deassertion.
- **Throughput.** One operation per `WIDTH+2` cycles at most.

## Structure

- Shared defines file (`lib/defines.vh`) gains:
  - `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU` op codes.
  - `MD_IDLE`, `MD_CALC`, `MD_DONE` state codes.
  - `MD_OP_WD = 2`.
  - Existing `Stop`/`NoStop` are reused for `stallreq_o`.
- One sub-module, `muldiv_negabs`: combinational conditional two's-complement negate, parametrised by width. Instantiated for operand abs (`WIDTH`) and for result fix-up (2·`WIDTH`).
- Control FSM, counter and datapath live in `muldiv_unit`.

## Test plan

All scenarios use `WIDTH=32`.

1. **`MULT`:** `opa=-3` (`0xFFFFFFFD`), `opb=7` → `ready_o` 33 cycles after accept, `hi=0xFFFFFFFF`, `lo=0xFFFFFFEB`, `stallreq_o` high for 33 cycles.
2. **`MULTU`:** `opa=0xFFFFFFFF`, `opb=0xFFFFFFFF` → `hi=0xFFFFFFFE`, `lo=0x00000001`.
3. **`DIV` / `DIVU` with negatives:**
   - `DIV` −7 ÷ 2 → `lo=0xFFFFFFFD` (−3), `hi=0xFFFFFFFF` (−1).
   - `DIVU` `0x80000000` ÷ 3 → `lo=0x2AAAAAAA`, `hi=2`.
4. **Divide by zero:** `DIV 5/0` → `ready_o` the cycle after accept, `div_by_zero_o=1`, `hi=5`, `lo=0xFFFFFFFF`.
5. **Annul:** `annul_i` pulsed mid-`CALC` (cycle 10) → no `ready_o`, `busy_o` low the next cycle, prior `hi`/`lo` unchanged. Then a new `MULTU 6*7` gives `lo=42`.
6. **Async reset:** `rst` asserted mid-divide, between clock edges → `busy_o`, `hi_o` and `lo_o` are 0 before the next edge. `DIV` of min-negative by −1 after reset → `lo=0x80000000`, `hi=0`.
